fp16_add_arb: RTL and testbench
===============================

Name: fp16_add_arb

Overview:
- Round-robin scheduler that shares one pipelined fp16_add datapath among NUM_REQ independent requesters.
- Each requester hands over an operand pair with a valid/ready handshake. The block registers the winner into an issue stage, drives the adder, and tracks each in-flight operation's requester ID in a tag pipeline.
- Each result is returned with a one-hot response strobe to the originating requester.
- Sits between the vector/scalar front-ends and the single shared half-precision adder.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester index width, equal to clog2(NUM_REQ), minimum 1.
- ADD_LAT, 2, cycles from adder input change to adder registered result. Must equal the fp16_add pipeline depth.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset; asynchronous assert, active-high.
- req_valid  input  NUM_REQ  per-requester operand pair valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit set per cycle.
- req_a  input  16*NUM_REQ  operand A, requester i at bits [16*i+15:16*i].
- req_b  input  16*NUM_REQ  operand B, same packing.
- rsp_valid  output  NUM_REQ  one-hot result strobe, single cycle, no backpressure.
- rsp_result  output  16  fp16 sum, valid when any rsp_valid bit is set.
- rsp_id  output  ID_W  binary index of the responding requester.
- busy  output  1  high while any operation is in the issue stage or tag pipeline.

Behaviour:
- Reset: rst is asynchronous and active-high; clk and rst are the only clock and reset.
  - While rst is asserted: rr_ptr=NUM_REQ-1, iss_valid=0, all tag-pipeline valids=0, rsp_valid=0, rsp_result=0, rsp_id=0, busy=0.
  - The adder instance receives rst_n = ~rst.
  - Asserting rst mid-operation discards all in-flight operations; no rsp_valid is emitted for them after release.
- Arbitration (combinational, every cycle):
  - Scan req_valid starting at index rr_ptr+1, modulo NUM_REQ; the first set bit wins.
  - req_ready[winner]=1, all other req_ready bits are 0. If no req_valid bit is set, req_ready=0.
  - The block never stalls: req_ready may depend combinationally on req_valid. A requester must not make its req_valid depend on its req_ready.
  - A handshake completes when req_valid[i] & req_ready[i] are both high at the clock edge.
  - On a handshake rr_ptr <= winner. With no handshake rr_ptr holds.
- Fairness: with all NUM_REQ requesters continuously valid, grants rotate 0,1,2,...,NUM_REQ-1,0,...
  - No requester waits more than NUM_REQ-1 cycles once it is valid.
- Issue stage, registered on a handshake at edge t:
  - iss_valid=1, iss_id=winner, iss_a=req_a[winner], iss_b=req_b[winner].
  - With no handshake, iss_valid=0 and iss_a/iss_b hold their values (adder input stays quiet).
  - The adder's a and b inputs are driven directly from iss_a and iss_b.
- Tag pipeline:
  - ADD_LAT stages, each holding {valid, id}; stage 0 loads {iss_valid, iss_id}.
  - Output of the last stage, in the same cycle:
    - rsp_valid = valid ? onehot(id) : 0
    - rsp_id = id
    - rsp_result = adder result
- Latency: handshake at edge t produces the response during the cycle after edge t+1+ADD_LAT, i.e. 3 cycles after the handshake edge for ADD_LAT=2.
- Throughput: one operation per cycle; the issue stage plus the tag pipeline hold up to ADD_LAT+1 operations.
- Ordering: responses return in grant order. Back-to-back grants to the same requester produce back-to-back rsp_valid pulses.
- busy = iss_valid | OR of all tag-pipeline valid bits.
- rsp_result when rsp_valid=0 is don't-care for consumers; the bench must not check it.
- Arithmetic (truncation, flush-to-zero, NaN/Inf handling) is entirely the adder's; this block never modifies data.

Decomposition:
- Shared package/include (fp16_inc.vh):
  - FP16_QNAN, FP16_P_ZERO and the ID_W computation macro.
  - Reused by other shared-unit arbiters (fp16_mul).
- One sub-module, rr_arbiter:
  - Parameterized NUM_REQ, inputs req and advance, outputs grant_onehot and grant_idx, with an internal rr_ptr.
  - Reusable for the multiplier arbiter.
- This block instantiates rr_arbiter and fp16_add, and implements the issue stage and tag pipeline itself.

Test Plan:
- Single request: req_valid=0001, a=0x3C00, b=0x3C00 at edge 0 → req_ready=0001 in that cycle; rsp_valid=0001, rsp_id=0, rsp_result=0x4000 three cycles later; busy low afterwards.
- All four requesters valid continuously, each with a=0x4000, b=0x4200 → grants rotate 0,1,2,3,0; responses one per cycle with rsp_result=0x4500 and rsp_id sequence 0,1,2,3,0.
- Requester 2 alone, valid for 5 consecutive cycles with varying operands → 5 back-to-back grants; 5 consecutive rsp_valid=0100 pulses in order; no bubbles.
- Special values: requester 1 sends a=0x7C00, b=0xFC00 → rsp_result=FP16_QNAN, rsp_valid=0010.
- Pointer check: rr_ptr=1, then req_valid=1001 → requester 3 granted first, then requester 0.
- Reset mid-flight: three grants issued, rst pulsed high for 1 cycle before any response → no rsp_valid ever emitted for them; busy=0 and rsp_valid=0 during and after reset; next request after release arbitrates starting from index 0.

Source files
------------

// File: rtl/fp16_add_arb_pkg.sv
// Shared constants, tag width helper and adder stage-1 payload for the
// fp16 shared-unit arbiters.
package fp16_add_arb_pkg;

  localparam logic [15:0] FP16_QNAN   = 16'h7E00;
  localparam logic [15:0] FP16_P_ZERO = 16'h0000;

  // Requester index width: clog2(n), never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic              sign;
    logic signed [6:0] expo;
    logic [14:0]       mag;      // carry, hidden bit, 10 fraction, 3 guard
    logic              special;
    logic [15:0]       special_val;
  } add_s1_t;

endpackage

// File: rtl/fp16_add.sv
// Two-stage half-precision adder: align/add, then normalize/pack.
// Truncating rounding, subnormals flushed to zero, NaN results are FP16_QNAN.
module fp16_add
  import fp16_add_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result
);

  logic        a_inf, b_inf, a_nan, b_nan, a_big, sx, sy;
  logic [14:0] mag_a, mag_b, mag_x, mag_y, sum;
  logic [13:0] mx, my, my_al;
  logic [4:0]  d;
  add_s1_t     s1_d, s1;

  assign a_inf = (a[14:10] == 5'h1f) && (a[9:0] == '0);
  assign b_inf = (b[14:10] == 5'h1f) && (b[9:0] == '0);
  assign a_nan = (a[14:10] == 5'h1f) && (a[9:0] != '0);
  assign b_nan = (b[14:10] == 5'h1f) && (b[9:0] != '0);
  assign mag_a = (a[14:10] == '0) ? '0 : a[14:0];
  assign mag_b = (b[14:10] == '0) ? '0 : b[14:0];
  assign a_big = mag_a >= mag_b;
  assign sx    = a_big ? a[15] : b[15];
  assign sy    = a_big ? b[15] : a[15];
  assign mag_x = a_big ? mag_a : mag_b;
  assign mag_y = a_big ? mag_b : mag_a;
  assign mx    = (mag_x == '0) ? '0 : {1'b1, mag_x[9:0], 3'b000};
  assign my    = (mag_y == '0) ? '0 : {1'b1, mag_y[9:0], 3'b000};
  assign d     = mag_x[14:10] - mag_y[14:10];

  // Bits shifted out of the smaller operand collapse into a sticky LSB.
  always_comb begin
    my_al = '0;
    if (d >= 5'd14) my_al = {13'b0, |my};
    else begin
      my_al    = my >> d;
      my_al[0] = my_al[0] | (|(my & ~(14'h3fff << d)));
    end
  end

  assign sum = (sx == sy) ? ({1'b0, mx} + {1'b0, my_al}) : ({1'b0, mx} - {1'b0, my_al});

  always_comb begin
    s1_d             = '0;
    s1_d.sign        = sx;
    s1_d.expo        = $signed({2'b00, mag_x[14:10]});
    s1_d.mag         = sum;
    s1_d.special     = a_nan | b_nan | a_inf | b_inf;
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15])))
      s1_d.special_val = FP16_QNAN;
    else if (a_inf) s1_d.special_val = {a[15], 5'h1f, 10'h000};
    else            s1_d.special_val = {b[15], 5'h1f, 10'h000};
  end

  logic [3:0]        lz;
  logic [9:0]        frac;
  logic signed [6:0] e;
  logic [15:0]       res;

  always_comb begin
    lz   = '0;
    frac = '0;
    e    = '0;
    res  = FP16_P_ZERO;
    for (int i = 0; i < 14; i++) if (s1.mag[i]) lz = 4'(13 - i);
    if (s1.mag[14]) begin
      frac = s1.mag[13:4];
      e    = s1.expo + 7'sd1;
    end else begin
      frac = 10'((s1.mag[13:0] << lz) >> 3);
      e    = s1.expo - $signed({3'b000, lz});
    end
    if (s1.special)          res = s1.special_val;
    else if (s1.mag == '0)   res = FP16_P_ZERO;
    else if (e >= 7'sd31)    res = {s1.sign, 5'h1f, 10'h000};
    else if (e <= 7'sd0)     res = {s1.sign, 15'h0000};
    else                     res = {s1.sign, e[4:0], frac};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      result <= '0;
    end else begin
      s1     <= s1_d;
      result <= res;
    end
  end

endmodule

// File: rtl/fp16_add_arb_rr_arbiter.sv
// Round-robin arbiter: scan starts just past the last winner.
module rr_arbiter
  import fp16_add_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_idx
);

  logic [ID_W-1:0] rr_ptr, idx;
  logic            hit;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    hit          = 1'b0;
    idx          = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = ID_W'((int'(rr_ptr) + off) % NUM_REQ);
      if (!hit && req[idx]) begin
        hit               = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_idx         = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                rr_ptr <= ID_W'(NUM_REQ - 1);
    else if (advance && hit) rr_ptr <= grant_idx;
  end

endmodule

// File: rtl/fp16_add_arb.sv
// Shares one pipelined fp16 adder among NUM_REQ requesters; requester IDs
// ride a tag pipeline alongside the adder and steer the one-hot response.
module fp16_add_arb
  import fp16_add_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ),
  parameter int ADD_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [15:0]            rsp_result,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
);

  logic [NUM_REQ-1:0][15:0]     a_vec, b_vec;
  logic [ID_W-1:0]              grant_idx, iss_id;
  logic                         hs, iss_valid;
  logic [15:0]                  iss_a, iss_b, add_result;
  logic [ADD_LAT-1:0]           vld_pipe;
  logic [ADD_LAT-1:0][ID_W-1:0] id_pipe;

  assign a_vec = req_a;
  assign b_vec = req_b;
  assign hs    = |(req_valid & req_ready);

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk          (clk),
    .rst          (rst),
    .req          (req_valid),
    .advance      (|req_valid),
    .grant_onehot (req_ready),
    .grant_idx    (grant_idx)
  );

  // Operands hold when idle so the adder inputs stay quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss_id    <= '0;
      iss_a     <= '0;
      iss_b     <= '0;
    end else begin
      iss_valid <= hs;
      if (hs) begin
        iss_id <= grant_idx;
        iss_a  <= a_vec[grant_idx];
        iss_b  <= b_vec[grant_idx];
      end
    end
  end

  fp16_add u_add (
    .clk    (clk),
    .rst_n  (~rst),
    .a      (iss_a),
    .b      (iss_b),
    .result (add_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[0] <= iss_valid;
      id_pipe[0]  <= iss_id;
      for (int i = 1; i < ADD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
    end
  end

  // Last tag stage lines up with the adder's registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= '0;
      rsp_id     <= '0;
      rsp_result <= FP16_P_ZERO;
    end else begin
      rsp_valid  <= vld_pipe[ADD_LAT-1] ? (NUM_REQ'(1) << id_pipe[ADD_LAT-1]) : '0;
      rsp_id     <= id_pipe[ADD_LAT-1];
      rsp_result <= add_result;
    end
  end

  assign busy = iss_valid | (|vld_pipe);

endmodule

// File: tb/tb_fp16_add_arb.sv
// Directed bench for fp16_add_arb: arbitration order, latency, data path,
// back-to-back issue and reset flush, with hand-computed expectations.
module tb_fp16_add_arb;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req_valid, req_ready, rsp_valid;
  logic [3:0][15:0] req_a, req_b;
  logic [15:0]      rsp_result;
  logic [1:0]       rsp_id;
  logic             busy;
  int               n_cmp = 0;
  int               n_err = 0;

  always #5 clk = ~clk;

  fp16_add_arb #(.NUM_REQ(4), .ID_W(2), .ADD_LAT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    repeat (3) step();
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    n_cmp++; if (rsp_result !== 16'h0000) begin n_err++; $display("FAIL reset_rsp_result: got %h want 0000", rsp_result); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    req_a[0] = 16'h3C00; req_b[0] = 16'h3C00; req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
    for (int c = 1; c <= 2; c++) begin
      step();
      n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL single_early_rsp c%0d: got %b want 0000", c, rsp_valid); end
    end
    step();
    n_cmp++; if (rsp_valid !== 4'b0001) begin n_err++; $display("FAIL single_rsp_valid: got %b want 0001", rsp_valid); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL single_rsp_id: got %0d want 0", rsp_id); end
    n_cmp++; if (rsp_result !== 16'h4000) begin n_err++; $display("FAIL single_rsp_result: got %h want 4000", rsp_result); end
    step();
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL single_rsp_end: got %b want 0000", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_rotate();
    int exp_g[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin req_a[i] = 16'h4000; req_b[i] = 16'h4200; end
    for (int c = 0; c < 9; c++) begin
      if (c < 5) begin
        req_valid = 4'b1111;
        #1;
        n_cmp++; if (req_ready !== 4'(1 << exp_g[c])) begin n_err++; $display("FAIL rotate_ready c%0d: got %b want %b", c, req_ready, 4'(1 << exp_g[c])); end
      end else req_valid = '0;
      step();
      if (c >= 3 && c <= 7) begin
        n_cmp++; if (rsp_valid !== 4'(1 << exp_g[c-3])) begin n_err++; $display("FAIL rotate_rsp_valid c%0d: got %b want %b", c, rsp_valid, 4'(1 << exp_g[c-3])); end
        n_cmp++; if (rsp_id !== 2'(exp_g[c-3])) begin n_err++; $display("FAIL rotate_rsp_id c%0d: got %0d want %0d", c, rsp_id, exp_g[c-3]); end
        n_cmp++; if (rsp_result !== 16'h4500) begin n_err++; $display("FAIL rotate_rsp_result c%0d: got %h want 4500", c, rsp_result); end
      end else begin
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL rotate_idle c%0d: got %b want 0000", c, rsp_valid); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va[5] = '{16'h3C00, 16'h4000, 16'h3C00, 16'h3C00, 16'h4000};
    logic [15:0] vb[5] = '{16'h3C00, 16'h4200, 16'hBC00, 16'h0000, 16'h3800};
    logic [15:0] ve[5] = '{16'h4000, 16'h4500, 16'h0000, 16'h3C00, 16'h4100};
    for (int c = 0; c < 9; c++) begin
      if (c < 5) begin
        req_a[2] = va[c]; req_b[2] = vb[c]; req_valid = 4'b0100;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL b2b_ready c%0d: got %b want 0100", c, req_ready); end
      end else req_valid = '0;
      step();
      if (c >= 3 && c <= 7) begin
        n_cmp++; if (rsp_valid !== 4'b0100) begin n_err++; $display("FAIL b2b_rsp_valid c%0d: got %b want 0100", c, rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd2) begin n_err++; $display("FAIL b2b_rsp_id c%0d: got %0d want 2", c, rsp_id); end
        n_cmp++; if (rsp_result !== ve[c-3]) begin n_err++; $display("FAIL b2b_rsp_result c%0d: got %h want %h", c, rsp_result, ve[c-3]); end
      end else begin
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL b2b_idle c%0d: got %b want 0000", c, rsp_valid); end
      end
    end
  endtask

  task automatic test_special();
    req_a[1] = 16'h7C00; req_b[1] = 16'hFC00; req_valid = 4'b0010;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL special_ready: got %b want 0010", req_ready); end
    step();
    req_valid = '0;
    repeat (2) step();
    step();
    n_cmp++; if (rsp_valid !== 4'b0010) begin n_err++; $display("FAIL special_rsp_valid: got %b want 0010", rsp_valid); end
    n_cmp++; if (rsp_id !== 2'd1) begin n_err++; $display("FAIL special_rsp_id: got %0d want 1", rsp_id); end
    n_cmp++; if (rsp_result !== 16'h7E00) begin n_err++; $display("FAIL special_rsp_result: got %h want 7e00", rsp_result); end
    step();
  endtask

  // Pointer is left at 1 by the previous grant to requester 1.
  task automatic test_pointer();
    int exp_g[2] = '{3, 0};
    req_a[3] = 16'h3C00; req_b[3] = 16'h3C00; req_a[0] = 16'h4000; req_b[0] = 16'h4200;
    for (int c = 0; c < 6; c++) begin
      if (c < 2) begin
        req_valid = 4'b1001;
        #1;
        n_cmp++; if (req_ready !== 4'(1 << exp_g[c])) begin n_err++; $display("FAIL pointer_ready c%0d: got %b want %b", c, req_ready, 4'(1 << exp_g[c])); end
      end else req_valid = '0;
      step();
      if (c >= 3 && c <= 4) begin
        n_cmp++; if (rsp_id !== 2'(exp_g[c-3])) begin n_err++; $display("FAIL pointer_rsp_id c%0d: got %0d want %0d", c, rsp_id, exp_g[c-3]); end
        n_cmp++; if (rsp_valid !== 4'(1 << exp_g[c-3])) begin n_err++; $display("FAIL pointer_rsp_valid c%0d: got %b want %b", c, rsp_valid, 4'(1 << exp_g[c-3])); end
      end
    end
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL pointer_idle: got %b want 0000", rsp_valid); end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 4; i++) begin req_a[i] = 16'h3C00; req_b[i] = 16'h4000; end
    req_valid = 4'b1111;
    repeat (3) step();
    req_valid = '0;
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL midrst_rsp_valid: got %b want 0000", rsp_valid); end
    step();
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL midrst_hold: got %b want 0000", rsp_valid); end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      n_cmp++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL midrst_after c%0d: got rsp %b busy %b want 0000/0", c, rsp_valid, busy); end
    end
    req_valid = 4'b1111;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL midrst_restart_ready: got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    repeat (3) step();
    n_cmp++; if (rsp_valid !== 4'b0001) begin n_err++; $display("FAIL midrst_restart_rsp: got %b want 0001", rsp_valid); end
    n_cmp++; if (rsp_result !== 16'h4200) begin n_err++; $display("FAIL midrst_restart_result: got %h want 4200", rsp_result); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotate();
    test_back_to_back();
    test_special();
    test_pointer();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
